// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared types and helpers for the pipelined add/subtract unit.
//   addsub_op_e : operation encoding (ADD, SUB, ADC, SBC)
//   nzcv_t      : ARM-style condition flags
//   seg_width() : width of one carry segment
//   config_ok() : legality check of the WIDTH/STAGES pair, used at elaboration
// ---------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } addsub_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // The carry chain is cut into equal segments, so WIDTH must divide evenly.
    function automatic bit config_ok(input int width, input int stages);
        return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// ---------------------------------------------------------------------------
// addsub_segment
// Combinational SEG-bit adder slice of the segmented carry chain.
// Ports:
//   a, b   in  SEG  operand slices (b already conditioned for subtraction)
//   cin    in  1    carry into the slice
//   sum    out SEG  slice sum
//   cout   out 1    carry out of the slice's top bit
//   c_msb  out 1    carry into the slice's top bit (overflow = c_msb ^ cout
//                   when this is the most significant slice)
// ---------------------------------------------------------------------------
module addsub_segment #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    generate
        if (SEG == 1) begin : g_single_bit
            logic [1:0] full;
            assign full  = {1'b0, a} + {1'b0, b} + {1'b0, cin};
            assign sum   = full[0];
            assign cout  = full[1];
            assign c_msb = cin;
        end else begin : g_multi_bit
            // Split off the top bit so the carry into it is observable.
            logic [SEG-1:0] low;
            logic [1:0]     top;
            assign low   = {1'b0, a[SEG-2:0]} + {1'b0, b[SEG-2:0]} + {{(SEG-1){1'b0}}, cin};
            assign c_msb = low[SEG-1];
            assign top   = {1'b0, a[SEG-1]} + {1'b0, b[SEG-1]} + {1'b0, c_msb};
            assign sum   = {top[0], low[SEG-2:0]};
            assign cout  = top[1];
        end
    endgenerate

endmodule

// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
// Pipelined two's-complement ADD/SUB/ADC/SBC with ARM NZCV flags. The
// WIDTH-bit carry chain is split into STAGES segments, one per clock.
// Latency is STAGES cycles from the accepting edge; throughput 1 op/cycle.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   flush                   pipeline clear (only with ADDSUB_FLUSH_EN defined)
//   in_valid/in_ready       input handshake
//   in_a, in_b, in_op       operands and operation (00 ADD,01 SUB,10 ADC,11 SBC)
//   in_carry, in_tag        carry-in for ADC/SBC, pass-through tag
//   out_valid/out_ready     output handshake
//   out_sum, out_n/z/c/v    result and flags
//   out_tag                 tag of the result
//
// Optional feature macro: ADDSUB_FLUSH_EN adds the flush port.
// ---------------------------------------------------------------------------
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
`ifdef ADDSUB_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    generate
        if (!config_ok(WIDTH, STAGES)) begin : g_bad_config
            $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic adv;
    logic flush_now;
    logic in_fire;

`ifdef ADDSUB_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // One global enable: everything moves unless the result is stuck.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !flush_now;
    assign in_fire  = in_valid && in_ready;

    // ---------------------------------------------------------------------
    // Operand conditioning
    // ---------------------------------------------------------------------
    addsub_op_e       op;
    logic [WIDTH-1:0] b_cond;
    logic             cin;

    assign op = addsub_op_e'(in_op);

    always_comb begin
        b_cond = in_b;
        cin    = 1'b0;
        case (op)
            OP_ADD: begin b_cond = in_b;  cin = 1'b0;     end
            OP_SUB: begin b_cond = ~in_b; cin = 1'b1;     end
            OP_ADC: begin b_cond = in_b;  cin = in_carry; end
            OP_SBC: begin b_cond = ~in_b; cin = in_carry; end
            default: begin b_cond = in_b; cin = 1'b0;     end
        endcase
    end

    // ---------------------------------------------------------------------
    // Pipeline ranks. Rank k holds the operation about to add segment k:
    // operands, carry into segment k, and the lower segments already summed.
    // Consumed operand bits are dead past their segment and get trimmed.
    // ---------------------------------------------------------------------
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] carry_reg;
    logic [WIDTH-1:0]  a_reg   [STAGES];
    logic [WIDTH-1:0]  b_reg   [STAGES];
    logic [WIDTH-1:0]  sum_reg [STAGES];
    logic [TAG_W-1:0]  tag_reg [STAGES];

    logic [STAGES-1:0][SEG-1:0] seg_sum;
    logic [STAGES-1:0]          seg_cout;
    logic [STAGES-1:0]          seg_cmsb;
    logic [WIDTH-1:0]           sum_next [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
            addsub_segment #(
                .SEG (SEG)
            ) u_segment (
                .a     (a_reg[gi][gi*SEG +: SEG]),
                .b     (b_reg[gi][gi*SEG +: SEG]),
                .cin   (carry_reg[gi]),
                .sum   (seg_sum[gi]),
                .cout  (seg_cout[gi]),
                .c_msb (seg_cmsb[gi])
            );
        end
    endgenerate

    // Merge each rank's freshly computed segment into its partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_next[k]              = sum_reg[k];
            sum_next[k][k*SEG +: SEG] = seg_sum[k];
        end
    end

    nzcv_t flags_next;
    nzcv_t flags_reg;

    always_comb begin
        flags_next   = '0;
        flags_next.n = sum_next[STAGES-1][WIDTH-1];
        flags_next.z = (sum_next[STAGES-1] == '0);
        flags_next.c = seg_cout[STAGES-1];
        // Signed overflow: carry into the MSB differs from carry out of it.
        flags_next.v = seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            carry_reg <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k]   <= '0;
                b_reg[k]   <= '0;
                sum_reg[k] <= '0;
                tag_reg[k] <= '0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            flags_reg <= '0;
            out_tag   <= '0;
        end else if (flush_now) begin
            // Only the valid bits matter; stale data is never presented.
            valid_reg <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            valid_reg[0] <= in_fire;
            a_reg[0]     <= in_a;
            b_reg[0]     <= b_cond;
            carry_reg[0] <= cin;
            sum_reg[0]   <= '0;
            tag_reg[0]   <= in_tag;
            for (int k = 1; k < STAGES; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                a_reg[k]     <= a_reg[k-1];
                b_reg[k]     <= b_reg[k-1];
                carry_reg[k] <= seg_cout[k-1];
                sum_reg[k]   <= sum_next[k-1];
                tag_reg[k]   <= tag_reg[k-1];
            end
            out_valid <= valid_reg[STAGES-1];
            out_sum   <= sum_next[STAGES-1];
            flags_reg <= flags_next;
            out_tag   <= tag_reg[STAGES-1];
        end
    end

    assign out_n = flags_reg.n;
    assign out_z = flags_reg.z;
    assign out_c = flags_reg.c;
    assign out_v = flags_reg.v;

endmodule

// File: tb/tb_pipelined_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_addsub
// Directed vectors with hand-computed results; expected responses are queued
// at issue time and a separate monitor pops/compares on each output transfer.
// ---------------------------------------------------------------------------
module tb_pipelined_addsub;

    localparam int W  = 64;
    localparam int S  = 4;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [1:0]    in_op = 2'b00;
    logic          in_carry = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic          out_n, out_z, out_c, out_v;
    logic [TW-1:0] out_tag;
`ifdef ADDSUB_FLUSH_EN
    logic          flush = 1'b0;
`endif

    pipelined_addsub #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef ADDSUB_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_n     (out_n),
        .out_z     (out_z),
        .out_c     (out_c),
        .out_v     (out_v),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] sum;
        logic [3:0]  nzcv;
        logic [4:0]  tag;
        bit          lat_chk;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t        e;
        bit          stall_prev;
        logic [63:0] hold_sum;
        logic [3:0]  hold_flags;
        logic [4:0]  hold_tag;
        stall_prev = 0;
        hold_sum   = '0;
        hold_flags = '0;
        hold_tag   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_sum", out_sum, hold_sum);
                    check("hold_flags", {out_n, out_z, out_c, out_v}, hold_flags);
                    check("hold_tag", out_tag, hold_tag);
                end
                if (out_valid && !out_ready) begin
                    check("in_ready_low_on_stall", in_ready, 0);
                    hold_sum   = out_sum;
                    hold_flags = {out_n, out_z, out_c, out_v};
                    hold_tag   = out_tag;
                    stall_prev = 1;
                end else begin
                    stall_prev = 0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output tag=%0d sum=0x%0h required=none", out_tag, out_sum);
                    end else begin
                        e = sb.pop_front();
                        $display("result tag=%0d sum=0x%016h nzcv=%b", out_tag, out_sum, {out_n, out_z, out_c, out_v});
                        check("sum", out_sum, e.sum);
                        check("nzcv", {out_n, out_z, out_c, out_v}, e.nzcv);
                        check("tag", out_tag, e.tag);
                        if (e.lat_chk) check("latency", cyc, e.acc_cyc + S);
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic [4:0] tag,
                        input logic [63:0] esum, input logic [3:0] enzcv,
                        input bit push, input bit lat);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_carry = c;
        in_tag   = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) sb.push_back('{esum, enzcv, tag, lat, cyc + 1});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout tag=%0d in_ready=0 required=1", tag);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) return;
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        sb.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_flags", {out_n, out_z, out_c, out_v}, 0);
        check("reset_out_tag", out_tag, 0);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Single ops with exact latency check, issued back to back.
        send(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 5'd3, 64'h8000_0000_0000_0000, 4'b1001, 1, 1);
        send(2'b01, 64'h5, 64'h5, 0, 5'd4, 64'h0, 4'b0110, 1, 1);
        send(2'b01, 64'h0, 64'h1, 0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1, 1);
        send(2'b10, 64'h0000_0000_0000_FFFF, 64'h0, 1, 5'd6, 64'h0000_0000_0001_0000, 4'b0000, 1, 1);
        send(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010, 1, 1);
        wait_drain();

        // Six back-to-back ops with a 3-cycle output stall mid-stream.
        fork
            begin
                send(2'b00, 64'd1, 64'd2, 0, 5'd0, 64'd3, 4'b0000, 1, 0);
                send(2'b01, 64'd10, 64'd3, 0, 5'd1, 64'd7, 4'b0010, 1, 0);
                send(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 5'd2, 64'd0, 4'b0110, 1, 0);
                send(2'b11, 64'd5, 64'd3, 0, 5'd3, 64'd1, 4'b0010, 1, 0);
                send(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 5'd4, 64'd0, 4'b0111, 1, 0);
                send(2'b01, 64'd3, 64'd5, 0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Asynchronous reset with one result stalled and three in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 64'd100, 64'(i), 0, 5'(10 + i), 64'(100 + i), 4'b0000, 1, 0);
        end
        @(posedge clk);
        #2;
        check("out_valid_before_reset", out_valid, 1);
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_out_sum", out_sum, 0);
        check("async_reset_out_tag", out_tag, 0);
        sb.delete();
        @(posedge clk);
        #3;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (8) @(posedge clk);
        #1;
        send(2'b00, 64'h1234, 64'h1111, 0, 5'd7, 64'h2345, 4'b0000, 1, 1);
        wait_drain();

`ifdef ADDSUB_FLUSH_EN
        // Flush with four ops in flight plus a same-cycle input.
        for (int i = 0; i < 4; i++) begin
            send(2'b00, 64'd1, 64'(i), 0, 5'(20 + i), 64'd0, 4'b0000, 0, 0);
        end
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_a     = 64'd42;
        in_b     = 64'd1;
        in_tag   = 5'd30;
        flush    = 1'b1;
        #1;
        check("in_ready_during_flush", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        send(2'b01, 64'h100, 64'h1, 0, 5'd8, 64'hFF, 4'b0010, 1, 1);
        wait_drain();
`endif

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement add/subtract unit for the execute stage. Supports ADD, SUB, ADC and SBC.
- Produces ARM NZCV flags for every result.
- Splits the WIDTH-bit carry chain into STAGES equal segments, one segment per clock, to meet timing at 64 bits.
- Valid/ready handshake with backpressure and a pass-through tag for the destination register.

Parameters:
- WIDTH, 64: operand and result width. Must be ≥ 2 and divisible by STAGES.
- STAGES, 4: pipeline depth, equal to the number of carry segments. SEG = WIDTH/STAGES.
- TAG_W, 5: sideband tag width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  unit can accept an operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBC
- in_carry  in  1  carry flag input, used by ADC/SBC
- in_tag  in  TAG_W  tag, returned with the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  result
- out_n, out_z, out_c, out_v  out  1 each  negative, zero, carry, overflow flags
- out_tag  out  TAG_W  tag of the result
- flush  in  1  present only when ADDSUB_FLUSH_EN is defined

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - all stage valid bits = 0 and out_valid = 0;
  - out_sum, flags and out_tag = 0;
  - in_ready = 1 after reset deasserts.
- Operand conditioning at input:
  - B' = in_b for ADD/ADC; B' = ~in_b for SUB/SBC.
  - cin = 0 for ADD, 1 for SUB, in_carry for ADC and SBC.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and B' with the carry registered from stage k-1 (stage 0 uses cin).
  - Upper operand segments travel skewed in pipeline registers.
  - Completed lower sum segments travel forward with the operation.
- Advance rule:
  - adv = !out_valid || out_ready, one global enable for all stage registers.
  - in_ready = adv. An input transfers when in_valid && in_ready.
  - Bubbles are not compressed.
- Latency is exactly STAGES cycles from the accepting edge to out_valid when out_ready is held high. Throughput is 1 op/cycle.
- Flags, registered with the final stage:
  - N = sum[WIDTH-1].
  - Z = (sum == 0).
  - C = carry out of bit WIDTH-1. For SUB/SBC, C = 1 means no borrow (ARM convention).
  - V = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]).
- Hold: while out_valid && !out_ready, every output and all internal stages hold stable; no operation is lost or duplicated.
- Boundary cases:
  - Simultaneous output drain and input accept in the same cycle is legal.
  - Reset mid-operation discards all in-flight operations.
  - in_op/in_b/in_carry are sampled only on transfer.
- Flags are compared exactly. in_* values are don't-care when in_valid = 0.

Optional Feature:
- Macro: ADDSUB_FLUSH_EN.
- Defined: the `flush` port exists. flush = 1 on a clock edge clears every stage valid bit and out_valid in that edge. Flush has priority over adv and over a simultaneous input transfer; the input is dropped. in_ready is forced 0 during flush.
- Not defined: the port is absent and the pipeline is never cleared except by reset.

Decomposition:
- Package addsub_pkg holds:
  - addsub_op_e enum (OP_ADD, OP_SUB, OP_ADC, OP_SBC);
  - the nzcv_t packed struct;
  - the constant function seg_width(WIDTH, STAGES);
  - an elaboration check that WIDTH % STAGES == 0.
- Sub-module addsub_segment: combinational SEG-bit adder with carry-in and carry-out; its top bit also exports the carry into the MSB for the overflow check. Instantiated STAGES times in a generate loop.
- The top level owns all registers and the handshake.

Test Plan:
- WIDTH=64, STAGES=4. ADD 0x7FFF_FFFF_FFFF_FFFF + 1, tag 3 → after 4 cycles: sum 0x8000_0000_0000_0000, NZCV = 1001, tag 3.
- SUB 5 − 5 → sum 0, NZCV = 0110. SUB 0 − 1 → sum 0xFFFF_FFFF_FFFF_FFFF, NZCV = 1000.
- ADC 0x0000_0000_0000_FFFF + 0, in_carry = 1 → sum 0x0000_0000_0001_0000. This proves carry crosses the segment boundary. NZCV = 0000.
- Six back-to-back ops, tags 0..5, with out_ready low for 3 cycles mid-stream:
  - in_ready drops while out_valid && !out_ready;
  - outputs stay stable;
  - all six results emerge in tag order, none lost or duplicated.
- Reset asserted asynchronously with 3 ops in flight → out_valid = 0 immediately, nothing emitted afterward, next op has 4-cycle latency.
- With ADDSUB_FLUSH_EN defined: flush with 4 ops in flight plus a same-cycle input → no results emerge, and the next accepted op returns correctly after 4 cycles.
